fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: controller and instruction-memory
// signals shared between the fetch unit and its neighbours.
interface fetch_unit_if;
  logic       loadIR;
  logic       incPC;
  logic       loadPC;
  logic       selPC;
  logic [7:0] regData;
  logic       halt;
  logic [7:0] memRdata;
  logic       memAck;
  logic [7:0] memAddr;
  logic       memReq;
  logic [7:0] pc;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [7:0] immExt;
  logic       stall;
  logic       seqErr;

  modport master (
    output loadIR, incPC, loadPC, selPC, regData,
    output halt, memRdata, memAck,
    input  memAddr, memReq, pc, opcode, operand,
    input  immExt, stall, seqErr
  );

  modport slave (
    input  loadIR, incPC, loadPC, selPC, regData,
    input  halt, memRdata, memAck,
    output memAddr, memReq, pc, opcode, operand,
    output immExt, stall, seqErr
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with wait-state
// memory handshake, branch load, halt and error flag.
module fetch_unit (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] pc_q, pc_nx;
  logic [7:0] ir_q, ir_nx;
  logic       inc_pend, inc_pend_nx;
  logic       seq_err, seq_err_nx;
  logic       mem_req;
  logic       stall_c;
  logic [7:0] imm;

  assign imm = {4'b0000, ir_q[3:0]};

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc_q     <= 8'h00;
      ir_q     <= 8'h00;
      inc_pend <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      pc_q     <= pc_nx;
      ir_q     <= ir_nx;
      inc_pend <= inc_pend_nx;
      seq_err  <= seq_err_nx;
    end
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_nx    = state;
    pc_nx       = pc_q;
    ir_nx       = ir_q;
    inc_pend_nx = inc_pend;
    seq_err_nx  = seq_err;
    mem_req     = 1'b0;
    stall_c     = 1'b0;
    unique case (state)
      RUN: begin
        // a branch load suppresses the fetch request
        mem_req = bus.loadIR & ~bus.loadPC;
        if (bus.halt) begin
          state_nx    = HALTED;
          inc_pend_nx = 1'b0;
        end else begin
          if (bus.incPC && !bus.loadIR)
            seq_err_nx = 1'b1;
          if (bus.loadPC) begin
            pc_nx = bus.selPC ? imm : bus.regData;
            if (bus.loadIR)
              seq_err_nx = 1'b1;
          end else if (bus.loadIR) begin
            if (bus.memAck) begin
              ir_nx = bus.memRdata;
              if (bus.incPC)
                pc_nx = pc_q + 8'd1;
            end else begin
              state_nx    = WAIT_MEM;
              inc_pend_nx = bus.incPC;
            end
          end
        end
      end
      WAIT_MEM: begin
        mem_req = 1'b1;
        stall_c = 1'b1;
        if (bus.halt) begin
          state_nx    = HALTED;
          inc_pend_nx = 1'b0;
        end else if (bus.memAck) begin
          ir_nx       = bus.memRdata;
          inc_pend_nx = 1'b0;
          state_nx    = RUN;
          if (inc_pend)
            pc_nx = pc_q + 8'd1;
        end
      end
      HALTED: begin
        state_nx = HALTED;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  assign bus.memReq  = mem_req & ~rst;
  assign bus.stall   = stall_c & ~rst;
  assign bus.memAddr = pc_q;
  assign bus.pc      = pc_q;
  assign bus.opcode  = ir_q[7:4];
  assign bus.operand = ir_q[3:0];
  assign bus.immExt  = imm;
  assign bus.seqErr  = seq_err;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of
// fetch_unit against a behavioural reference model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] m_pc, m_ir;
  bit         m_wait, m_halt, m_inc, m_err;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00;
    m_wait = 0; m_halt = 0; m_inc = 0; m_err = 0;
  endtask

  // Spec-level effect of one rising edge on the model
  task automatic model_edge();
    logic [7:0] imm;
    imm = {4'h0, m_ir[3:0]};
    if (m_halt) begin
    end else if (bus.halt) begin
      m_halt = 1; m_wait = 0; m_inc = 0;
    end else if (m_wait) begin
      if (bus.memAck) begin
        m_ir = bus.memRdata;
        m_pc = 8'((int'(m_pc) + int'(m_inc)) % 256);
        m_inc = 0; m_wait = 0;
      end
    end else begin
      if (bus.incPC && !bus.loadIR) m_err = 1;
      if (bus.loadPC) begin
        m_pc = bus.selPC ? imm : bus.regData;
        if (bus.loadIR) m_err = 1;
      end else if (bus.loadIR) begin
        if (bus.memAck) begin
          m_ir = bus.memRdata;
          if (bus.incPC) m_pc = 8'((int'(m_pc) + 1) % 256);
        end else begin
          m_wait = 1; m_inc = bus.incPC;
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    logic req, stl;
    req = !rst && !m_halt && (m_wait || (bus.loadIR && !bus.loadPC));
    stl = !rst && !m_halt && m_wait;
    chk({tag, ".pc"}, bus.pc, m_pc);
    chk({tag, ".addr"}, bus.memAddr, m_pc);
    chk({tag, ".opc"}, 8'(bus.opcode), 8'(m_ir[7:4]));
    chk({tag, ".opd"}, 8'(bus.operand), 8'(m_ir[3:0]));
    chk({tag, ".imm"}, bus.immExt, {4'h0, m_ir[3:0]});
    chk({tag, ".req"}, 8'(bus.memReq), 8'(req));
    chk({tag, ".stall"}, 8'(bus.stall), 8'(stl));
    chk({tag, ".err"}, 8'(bus.seqErr), 8'(m_err));
  endtask

  task automatic step(string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.loadIR = 0; bus.incPC = 0; bus.loadPC = 0;
    bus.selPC = 0; bus.halt = 0; bus.memAck = 0;
  endtask

  task automatic pulse_rst(string tag);
    #2 rst = 1;
    model_reset();
    #1 check_all(tag);
    #2 rst = 0;
  endtask

  initial begin
    idle();
    bus.regData = 8'h00;
    bus.memRdata = 8'h00;
    model_reset();
    #8 check_all("reset");
    chk("reset.pc0", bus.pc, 8'h00);
    #4 rst = 0;

    // zero-wait fetch
    bus.memRdata = 8'h1A;
    bus.loadIR = 1; bus.incPC = 1; bus.memAck = 1;
    step("zw");
    idle();
    chk("zw.opcode", 8'(bus.opcode), 8'h01);
    chk("zw.operand", 8'(bus.operand), 8'h0A);
    chk("zw.pc", bus.pc, 8'h01);
    chk("zw.stall", 8'(bus.stall), 8'h00);

    // wait states
    bus.loadIR = 1; bus.incPC = 1; bus.memAck = 0;
    step("ws0");
    chk("ws.stall1", 8'(bus.stall), 8'h01);
    step("ws1");
    step("ws2");
    chk("ws.stall3", 8'(bus.stall), 8'h01);
    bus.memAck = 1; bus.memRdata = 8'h7C;
    step("ws3");
    idle();
    chk("ws.ir", {bus.opcode, bus.operand}, 8'h7C);
    chk("ws.pc", bus.pc, 8'h02);
    chk("ws.stall0", 8'(bus.stall), 8'h00);

    // branches
    bus.loadIR = 1; bus.memAck = 1; bus.memRdata = 8'h75;
    step("br.f");
    idle();
    bus.loadPC = 1; bus.selPC = 1;
    step("br.imm");
    chk("br.imm", bus.pc, 8'h05);
    bus.selPC = 0; bus.regData = 8'hC3;
    step("br.reg");
    chk("br.reg", bus.pc, 8'hC3);
    bus.regData = 8'hFF;
    step("br.ff");
    idle();
    bus.loadIR = 1; bus.incPC = 1; bus.memAck = 1;
    bus.memRdata = 8'h3B;
    step("br.wrap");
    idle();
    chk("br.wrap", bus.pc, 8'h00);

    // illegal loadPC with loadIR
    bus.loadPC = 1; bus.loadIR = 1; bus.selPC = 1;
    bus.incPC = 1; bus.memAck = 1; bus.memRdata = 8'h99;
    #1 chk("ill.req", 8'(bus.memReq), 8'h00);
    step("ill");
    idle();
    chk("ill.pc", bus.pc, 8'h0B);
    chk("ill.ir", {bus.opcode, bus.operand}, 8'h3B);
    chk("ill.err", 8'(bus.seqErr), 8'h01);
    step("ill.idle");
    chk("ill.sticky", 8'(bus.seqErr), 8'h01);

    // halt during wait with simultaneous ack
    bus.loadIR = 1; bus.memAck = 0;
    step("h.w");
    bus.halt = 1; bus.memAck = 1; bus.memRdata = 8'hEE;
    step("h.h");
    idle();
    chk("h.ir", {bus.opcode, bus.operand}, 8'h3B);
    chk("h.req", 8'(bus.memReq), 8'h00);
    bus.loadIR = 1; bus.incPC = 1; bus.memAck = 1;
    step("h.ign0");
    step("h.ign1");
    chk("h.ign.ir", {bus.opcode, bus.operand}, 8'h3B);
    idle();
    pulse_rst("h.rst");
    chk("h.rst.pc", bus.pc, 8'h00);
    chk("h.rst.ir", {bus.opcode, bus.operand}, 8'h00);
    chk("h.rst.err", 8'(bus.seqErr), 8'h00);

    // async reset while waiting
    bus.loadIR = 1; bus.incPC = 1; bus.memAck = 0;
    step("ar.f");
    bus.loadIR = 1; bus.incPC = 1; bus.memAck = 1;
    bus.memRdata = 8'h55;
    step("ar.ok");
    bus.memAck = 0;
    step("ar.w");
    #3 rst = 1;
    model_reset();
    #1;
    chk("ar.stall", 8'(bus.stall), 8'h00);
    chk("ar.req", 8'(bus.memReq), 8'h00);
    chk("ar.pc", bus.pc, 8'h00);
    chk("ar.ir", {bus.opcode, bus.operand}, 8'h00);
    #1 rst = 0;
    idle();
    bus.memAck = 1; bus.memRdata = 8'hA5;
    step("ar.late");
    chk("ar.late.ir", {bus.opcode, bus.operand}, 8'h00);
    idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(39) == 0) begin
        idle();
        pulse_rst("rnd.rst");
      end
      bus.loadIR   = ($urandom_range(2) != 0);
      bus.incPC    = bus.loadIR ? 1'($urandom_range(1))
                                : ($urandom_range(15) == 0);
      bus.loadPC   = ($urandom_range(5) == 0);
      bus.selPC    = 1'($urandom_range(1));
      bus.regData  = 8'($urandom);
      bus.halt     = ($urandom_range(49) == 0);
      bus.memAck   = 1'($urandom_range(1));
      bus.memRdata = 8'($urandom);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
